// File: rtl/mem_responder.sv
// Tagged memory responder: one LOAD/STORE per cycle, LOAD data returned with its tag LATENCY cycles after acceptance.
// Optional feature macro MEM_RESP_STALL_EN: LFSR-driven LOAD rejection to model a congested memory.
module mem_responder #(
    parameter int DEPTH       = 8192,
    parameter int LATENCY     = 8,
    parameter int OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_transaction_tag,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_data_tag
);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]          unified_memory [DEPTH-1:0];
    logic [OUTSTANDING:1] busy;
    logic [OUTSTANDING:1] busy_nxt;
    logic [3:0]           pipe_tag [LATENCY];
    logic [63:0]          pipe_dat [LATENCY];

    logic [3:0]      free_tag;
    logic            stall;
    logic            is_load;
    logic            is_store;
    logic            in_range;
    logic            accept;
    logic [IDXW-1:0] line;
    logic [63:0]     rd_dat;

    assign is_load  = (proc2mem_command == 2'd1);
    assign is_store = (proc2mem_command == 2'd2);
    assign in_range = ({3'b000, proc2mem_addr[31:3]} < 32'(DEPTH));
    assign line     = proc2mem_addr[IDXW+2:3];
    assign rd_dat   = in_range ? unified_memory[line] : 64'h0;

`ifdef MEM_RESP_STALL_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Lowest-numbered free tag, 0 when the pool is exhausted
    always_comb begin
        free_tag = 4'd0;
        for (int i = OUTSTANDING; i >= 1; i--) begin
            if (!busy[i]) begin
                free_tag = 4'(i);
            end
        end
    end

    assign accept                   = reset && is_load && !stall && (free_tag != 4'd0);
    assign mem2proc_transaction_tag = accept ? free_tag : 4'd0;

    // A returning tag is still busy during its return cycle, so set and clear never hit the same bit
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i <= OUTSTANDING; i++) begin
            if (mem2proc_data_tag == 4'(i)) begin
                busy_nxt[i] = 1'b0;
            end
            if (accept && free_tag == 4'(i)) begin
                busy_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i] <= 4'd0;
                pipe_dat[i] <= 64'h0;
            end
        end else begin
            busy        <= busy_nxt;
            pipe_tag[0] <= accept ? free_tag : 4'd0;
            pipe_dat[0] <= accept ? rd_dat : 64'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_tag[i] <= pipe_tag[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Storage is deliberately left unreset so benches can preload it
    always_ff @(posedge clock) begin
        if (reset && is_store && in_range) begin
            unified_memory[line] <= proc2mem_data;
        end
    end

    assign mem2proc_data_tag = pipe_tag[LATENCY-1];
    assign mem2proc_data     = pipe_dat[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a queue-based reference model; honours MEM_RESP_STALL_EN.
module tb_mem_responder;
    localparam int DEPTH       = 8192;
    localparam int LATENCY     = 8;
    localparam int OUTSTANDING = 4;
    localparam int NL          = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd   = 2'd0;
    logic [31:0] addr  = 32'h0;
    logic [63:0] wdat  = 64'h0;
    logic [3:0]  ttag;
    logic [3:0]  dtag;
    logic [63:0] rdat;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .OUTSTANDING(OUTSTANDING)) dut (
        .clock                    (clk),
        .reset                    (rst_n),
        .proc2mem_command         (cmd),
        .proc2mem_addr            (addr),
        .proc2mem_data            (wdat),
        .mem2proc_transaction_tag (ttag),
        .mem2proc_data            (rdat),
        .mem2proc_data_tag        (dtag)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] dat;
        int          due;
    } flight_t;

    flight_t     inflight [$];
    logic [63:0] mm [NL];
    int          cyc = 0;
    logic [7:0]  lf  = 8'hA5;

    function automatic bit tag_in_use(input int t);
        foreach (inflight[i]) if (int'(inflight[i].tag) == t) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, check against the model, then advance the model past the edge
    task automatic step(input bit r, input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        logic [3:0]  et;
        logic [3:0]  edt;
        logic [63:0] ed;
        logic [63:0] rd;
        bit          stall;
        bit          inr;
        int          ln;
        @(negedge clk);
        rst_n = r; cmd = c; addr = a; wdat = d;
        #1;
        ln    = int'(a >> 3);
        inr   = (a >> 3) < DEPTH;
        et    = 4'd0;
        edt   = 4'd0;
        ed    = 64'h0;
        stall = 1'b0;
`ifdef MEM_RESP_STALL_EN
        stall = (lf[1:0] == 2'b00);
`endif
        if (r) begin
            if (inflight.size() > 0 && inflight[0].due == cyc) begin
                edt = inflight[0].tag;
                ed  = inflight[0].dat;
            end
            if (c == 2'd1 && !stall) begin
                for (int t = 1; t <= OUTSTANDING; t++) begin
                    if (!tag_in_use(t)) begin
                        et = 4'(t);
                        break;
                    end
                end
            end
        end
        chk("txn_tag", {60'h0, ttag}, {60'h0, et});
        chk("data_tag", {60'h0, dtag}, {60'h0, edt});
        chk("data", rdat, ed);
        if (!r) begin
            inflight.delete();
            lf = 8'hA5;
        end else begin
            if (edt != 4'd0) void'(inflight.pop_front());
            rd = (inr && ln < NL) ? mm[ln] : 64'h0;
            if (et != 4'd0) inflight.push_back('{et, rd, cyc + LATENCY});
            if (c == 2'd2 && inr && ln < NL) mm[ln] = d;
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'd0, 32'h0, 64'h0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rc;
        int          sel;
        for (int i = 0; i < NL; i++) begin
            mm[i] = {$urandom, $urandom};
            dut.unified_memory[i] = mm[i];
        end
        mm[5] = 64'hDEAD_BEEF_0123_4567;
        dut.unified_memory[5] = mm[5];

        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 32'h28, 64'h0);

        // basic load of line 5
        step(1'b1, 2'd1, 32'h28, 64'h0);
        idle(LATENCY + 1);

        // back-to-back loads, pool exhaustion and tag reuse
        for (int i = 0; i < 14; i++) step(1'b1, 2'd1, 32'(((i % 6)) << 3), 64'h0);
        idle(LATENCY + 1);

        // store then immediate load to the same line
        step(1'b1, 2'd2, 32'h100, 64'h1111);
        step(1'b1, 2'd1, 32'h100, 64'h0);
        idle(LATENCY + 1);

        // out of range load and store, then confirm line 0 untouched
        step(1'b1, 2'd1, 32'h0001_0000, 64'h0);
        step(1'b1, 2'd2, 32'h0001_0000, 64'hFFFF_0000_FFFF_0000);
        step(1'b1, 2'd1, 32'h0000_0000, 64'h0);
        idle(LATENCY + 1);

        // reset while three loads are in flight
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 32'((i + 1) << 3), 64'h0);
        step(1'b0, 2'd0, 32'h0, 64'h0);
        idle(LATENCY + 2);
        step(1'b1, 2'd1, 32'h28, 64'h0);
        idle(LATENCY + 1);

        // continuous load stream
        for (int i = 0; i < 40; i++) step(1'b1, 2'd1, 32'($urandom_range(0, NL - 1) << 3), 64'h0);
        idle(LATENCY + 1);

        // random mix
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)      ra = 32'h0001_0000 + 32'($urandom_range(0, NL - 1) << 3);
            else if (sel == 1) ra = $urandom | 32'h8000_0000;
            else               ra = 32'($urandom_range(0, NL - 1) << 3) | 32'($urandom_range(0, 7));
            rc = 2'($urandom_range(0, 3));
            step($urandom_range(0, 199) != 0, rc, ra, {$urandom, $urandom});
        end
        idle(LATENCY + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
